// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: result sources, forward selects, PC source.
package hazard_pkg;

  typedef enum logic [1:0] {
    RES_ALU     = 2'b00,
    RES_LOAD    = 2'b01,
    RES_IMMPLUS = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RD   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MIMM = 2'b10,
    FWD_MALU = 2'b11
  } fwd_sel_e;

  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency ops: per-register busy bits, an
// outstanding-op counter and a sticky error for completions that match nothing.
module hazard_scoreboard #(
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rd_rs1,
  input  logic [REG_AW-1:0] rd_rs2,
  input  logic [REG_AW-1:0] rd_rd,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd,
  output logic [CW-1:0]     busy_count,
  output logic              error
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] busy;
  logic            set_hit;
  logic            clr_hit;
  logic            clr_miss;

  // Qualify set/clear requests; x0 is never tracked and stray completions are errors.
  always_comb begin
    set_hit  = set & (set_rd != '0);
    clr_hit  = clr & (clr_rd != '0) & busy[clr_rd];
    clr_miss = clr & ~clr_hit;
  end

  // Read ports reflect the registered busy state only; completions land at the edge.
  always_comb begin
    busy_rs1 = busy[rd_rs1];
    busy_rs2 = busy[rd_rs2];
    busy_rd  = busy[rd_rd];
  end

  // Busy/count/error state; the set is applied after the clear so it wins on the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      error      <= 1'b0;
    end else begin
      if (clr_hit) busy[clr_rd] <= 1'b0;
      if (set_hit) busy[set_rd] <= 1'b1;
      busy_count <= busy_count + CW'(set_hit) - CW'(clr_hit);
      if (clr_miss) error <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit for the 5-stage core: operand forwarding, load-use and
// long-latency stalls, branch flushes, with a scoreboard for out-of-order long ops.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Di_rs1,
  input  logic [REG_AW-1:0] Di_rs2,
  input  logic [REG_AW-1:0] Di_rd,
  input  logic              Di_regWrite,
  input  logic              Di_longOp,
  input  logic [REG_AW-1:0] Ei_rs1,
  input  logic [REG_AW-1:0] Ei_rs2,
  input  logic [REG_AW-1:0] Ei_rd,
  input  logic [1:0]        Ei_resultSrc,
  input  logic              Ei_regWrite,
  input  logic              Ei_longOp,
  input  logic [1:0]        Ei_PCSrc,
  input  logic [REG_AW-1:0] Mi_rd,
  input  logic [1:0]        Mi_resultSrc,
  input  logic              Mi_regWrite,
  input  logic [REG_AW-1:0] Wi_rd,
  input  logic              Wi_regWrite,
  input  logic              Li_done,
  input  logic [REG_AW-1:0] Li_rd,
  output logic [1:0]        Eo_forwardIn1Src,
  output logic [1:0]        Eo_forwardIn2Src,
  output logic              Fo_stall,
  output logic              Do_stall,
  output logic              Do_flush,
  output logic              Eo_flush,
  output logic [CW-1:0]     o_busyCount,
  output logic              o_sbError
);

  logic          busy_rs1;
  logic          busy_rs2;
  logic          busy_rd;
  logic          sb_set;
  logic          load_use;
  logic          long_raw;
  logic          long_waw;
  logic          full;
  logic          any_stall;
  logic          branch;
  logic [CW:0]   occupancy;

  // Priority: M ALU, M immPlus, then W; an M load match falls through to W.
  function automatic fwd_sel_e fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic [1:0]        m_src,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    if (rs == '0)                                  return FWD_RD;
    if (m_we && (rs == m_rd) && (m_src == RES_ALU))     return FWD_MALU;
    if (m_we && (rs == m_rd) && (m_src == RES_IMMPLUS)) return FWD_MIMM;
    if (w_we && (rs == w_rd))                      return FWD_WB;
    return FWD_RD;
  endfunction

  assign sb_set = Ei_longOp & Ei_regWrite & (Ei_rd != '0);

  hazard_scoreboard #(
    .REG_AW          (REG_AW),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set        (sb_set),
    .set_rd     (Ei_rd),
    .clr        (Li_done),
    .clr_rd     (Li_rd),
    .rd_rs1     (Di_rs1),
    .rd_rs2     (Di_rs2),
    .rd_rd      (Di_rd),
    .busy_rs1   (busy_rs1),
    .busy_rs2   (busy_rs2),
    .busy_rd    (busy_rd),
    .busy_count (o_busyCount),
    .error      (o_sbError)
  );

  // E-stage operand forward selects.
  always_comb begin
    Eo_forwardIn1Src = fwd_sel(Ei_rs1, Mi_rd, Mi_resultSrc, Mi_regWrite, Wi_rd, Wi_regWrite);
    Eo_forwardIn2Src = fwd_sel(Ei_rs2, Mi_rd, Mi_resultSrc, Mi_regWrite, Wi_rd, Wi_regWrite);
  end

  // Stall sources: load-use, long-op RAW/WAW (including the op issuing from E now), capacity.
  always_comb begin
    load_use  = (Ei_resultSrc == RES_LOAD) & Ei_regWrite & (Ei_rd != '0) &
                ((Ei_rd == Di_rs1) | (Ei_rd == Di_rs2));
    long_raw  = (busy_rs1 & (Di_rs1 != '0)) | (busy_rs2 & (Di_rs2 != '0)) |
                (Ei_longOp & (Ei_rd != '0) & ((Ei_rd == Di_rs1) | (Ei_rd == Di_rs2)));
    long_waw  = Di_regWrite & (Di_rd != '0) & (busy_rd | (Ei_longOp & (Ei_rd == Di_rd)));
    occupancy = {1'b0, o_busyCount} + {{CW{1'b0}}, Ei_longOp};
    full      = Di_longOp & (occupancy >= (CW+1)'(MAX_OUTSTANDING));
    any_stall = load_use | long_raw | long_waw | full;
  end

  // A redirect kills the stalled D instruction, so it overrides the hold.
  always_comb begin
    branch   = (Ei_PCSrc != PCSRC_PLUS4);
    Fo_stall = any_stall & ~branch;
    Do_stall = any_stall & ~branch;
    Do_flush = branch;
    Eo_flush = branch | any_stall;
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: constant vector table, directed
// multi-cycle sequences and randomized stimulus against an outstanding-list model.
module tb_hazard_unit_sb;

  localparam int MAX = 4;

  logic       clk;
  logic       rst;
  logic [4:0] Di_rs1, Di_rs2, Di_rd;
  logic       Di_regWrite, Di_longOp;
  logic [4:0] Ei_rs1, Ei_rs2, Ei_rd;
  logic [1:0] Ei_resultSrc;
  logic       Ei_regWrite, Ei_longOp;
  logic [1:0] Ei_PCSrc;
  logic [4:0] Mi_rd;
  logic [1:0] Mi_resultSrc;
  logic       Mi_regWrite;
  logic [4:0] Wi_rd;
  logic       Wi_regWrite;
  logic       Li_done;
  logic [4:0] Li_rd;
  logic [1:0] Eo_forwardIn1Src, Eo_forwardIn2Src;
  logic       Fo_stall, Do_stall, Do_flush, Eo_flush;
  logic [2:0] o_busyCount;
  logic       o_sbError;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: list of destination registers with an op in flight.
  int pend[$];
  bit err_m;

  hazard_unit_sb #(.REG_AW(5), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Di_rd(Di_rd),
    .Di_regWrite(Di_regWrite), .Di_longOp(Di_longOp),
    .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2), .Ei_rd(Ei_rd),
    .Ei_resultSrc(Ei_resultSrc), .Ei_regWrite(Ei_regWrite),
    .Ei_longOp(Ei_longOp), .Ei_PCSrc(Ei_PCSrc),
    .Mi_rd(Mi_rd), .Mi_resultSrc(Mi_resultSrc), .Mi_regWrite(Mi_regWrite),
    .Wi_rd(Wi_rd), .Wi_regWrite(Wi_regWrite),
    .Li_done(Li_done), .Li_rd(Li_rd),
    .Eo_forwardIn1Src(Eo_forwardIn1Src), .Eo_forwardIn2Src(Eo_forwardIn2Src),
    .Fo_stall(Fo_stall), .Do_stall(Do_stall),
    .Do_flush(Do_flush), .Eo_flush(Eo_flush),
    .o_busyCount(o_busyCount), .o_sbError(o_sbError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d_rs1, d_rs2, d_rd, d_rw;
    int e_rs1, e_rs2, e_rd, e_src, e_rw, e_pc;
    int m_rd, m_src, m_rw;
    int w_rd, w_rw;
    int x_f1, x_f2, x_st, x_df, x_ef;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_busy(input int r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fwd_ref(input int rs);
    if (rs == 0) return 0;
    if (Mi_regWrite && Mi_rd == rs && Mi_resultSrc == 2'd0) return 3;
    if (Mi_regWrite && Mi_rd == rs && Mi_resultSrc == 2'd2) return 2;
    if (Wi_regWrite && Wi_rd == rs) return 1;
    return 0;
  endfunction

  task automatic check_all();
    bit lu, raw, waw, full, any, br;
    int d1, d2, e;
    d1 = int'(Di_rs1); d2 = int'(Di_rs2); e = int'(Ei_rd);
    lu   = Ei_resultSrc == 2'd1 && Ei_regWrite && e != 0 && (e == d1 || e == d2);
    raw  = (d1 != 0 && is_busy(d1)) || (d2 != 0 && is_busy(d2)) ||
           (Ei_longOp && e != 0 && (e == d1 || e == d2));
    waw  = Di_regWrite && Di_rd != 0 && (is_busy(int'(Di_rd)) || (Ei_longOp && e == int'(Di_rd)));
    full = Di_longOp && (pend.size() + int'(Ei_longOp)) >= MAX;
    any  = lu || raw || waw || full;
    br   = Ei_PCSrc != 2'd0;
    chk("fwd1", Eo_forwardIn1Src, fwd_ref(int'(Ei_rs1)));
    chk("fwd2", Eo_forwardIn2Src, fwd_ref(int'(Ei_rs2)));
    chk("Fo_stall", Fo_stall, int'(any && !br));
    chk("Do_stall", Do_stall, int'(any && !br));
    chk("Do_flush", Do_flush, int'(br));
    chk("Eo_flush", Eo_flush, int'(br || any));
    chk("busyCount", o_busyCount, pend.size());
    chk("sbError", o_sbError, int'(err_m));
  endtask

  // Completion removes the entry first, so a same-cycle reissue to that register survives.
  task automatic model_step();
    int idx;
    if (Li_done) begin
      idx = -1;
      foreach (pend[i]) if (pend[i] == int'(Li_rd)) idx = i;
      if (idx >= 0 && Li_rd != 0) pend.delete(idx);
      else err_m = 1'b1;
    end
    if (Ei_longOp && Ei_regWrite && Ei_rd != 0) pend.push_back(int'(Ei_rd));
  endtask

  task automatic idle();
    Di_rs1 = '0; Di_rs2 = '0; Di_rd = '0; Di_regWrite = 0; Di_longOp = 0;
    Ei_rs1 = '0; Ei_rs2 = '0; Ei_rd = '0; Ei_resultSrc = '0;
    Ei_regWrite = 0; Ei_longOp = 0; Ei_PCSrc = '0;
    Mi_rd = '0; Mi_resultSrc = '0; Mi_regWrite = 0;
    Wi_rd = '0; Wi_regWrite = 0; Li_done = 0; Li_rd = '0;
  endtask

  task automatic settle();
    #1 check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic issue(input int rd);
    Ei_longOp = 1; Ei_regWrite = 1; Ei_rd = 5'(rd);
  endtask

  task automatic done(input int rd);
    Li_done = 1; Li_rd = 5'(rd);
  endtask

  vec_t vecs[17];

  initial begin
    vecs = '{
      '{1,2,3,1, 5,6,9,0,1,0, 5,0,1, 5,1, 3,0,0,0,0},
      '{1,2,3,1, 5,6,9,0,1,0, 5,2,1, 5,1, 2,0,0,0,0},
      '{1,2,3,1, 5,6,9,0,1,0, 5,0,0, 5,1, 1,0,0,0,0},
      '{1,2,3,1, 0,5,9,0,1,0, 5,0,1, 5,1, 0,3,0,0,0},
      '{1,2,3,1, 5,6,9,0,1,0, 5,1,1, 5,1, 1,0,0,0,0},
      '{1,2,3,1, 5,6,9,0,1,0, 5,1,1, 4,1, 0,0,0,0,0},
      '{1,2,3,1, 5,6,9,0,1,0, 5,3,1, 5,1, 1,0,0,0,0},
      '{1,2,3,1, 6,5,9,0,1,0, 7,0,1, 5,0, 0,0,0,0,0},
      '{1,2,3,1, 8,6,9,0,1,0, 5,0,1, 6,1, 0,1,0,0,0},
      '{1,3,4,1, 0,0,3,1,1,0, 0,0,0, 0,0, 0,0,1,0,1},
      '{1,3,4,1, 0,0,3,1,1,1, 0,0,0, 0,0, 0,0,0,1,1},
      '{1,3,4,1, 0,0,3,1,1,3, 0,0,0, 0,0, 0,0,0,1,1},
      '{1,2,4,1, 0,0,3,0,1,2, 0,0,0, 0,0, 0,0,0,1,1},
      '{0,2,4,1, 0,0,0,1,1,0, 0,0,0, 0,0, 0,0,0,0,0},
      '{3,2,4,1, 0,0,3,1,0,0, 0,0,0, 0,0, 0,0,0,0,0},
      '{1,3,4,1, 0,0,3,0,1,0, 0,0,0, 0,0, 0,0,0,0,0},
      '{3,1,4,1, 0,0,3,1,1,0, 0,0,0, 0,0, 0,0,1,0,1}
    };

    rst = 1'b1;
    err_m = 1'b0;
    idle();
    @(negedge clk);
    #1;
    chk("reset_count", o_busyCount, 0);
    chk("reset_error", o_sbError, 0);
    chk("reset_stall", Fo_stall, 0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational vector table with an empty scoreboard.
    foreach (vecs[i]) begin
      idle();
      Di_rs1 = 5'(vecs[i].d_rs1); Di_rs2 = 5'(vecs[i].d_rs2);
      Di_rd = 5'(vecs[i].d_rd); Di_regWrite = 1'(vecs[i].d_rw);
      Ei_rs1 = 5'(vecs[i].e_rs1); Ei_rs2 = 5'(vecs[i].e_rs2); Ei_rd = 5'(vecs[i].e_rd);
      Ei_resultSrc = 2'(vecs[i].e_src); Ei_regWrite = 1'(vecs[i].e_rw);
      Ei_PCSrc = 2'(vecs[i].e_pc);
      Mi_rd = 5'(vecs[i].m_rd); Mi_resultSrc = 2'(vecs[i].m_src); Mi_regWrite = 1'(vecs[i].m_rw);
      Wi_rd = 5'(vecs[i].w_rd); Wi_regWrite = 1'(vecs[i].w_rw);
      #1;
      chk($sformatf("vec%0d_fwd1", i), Eo_forwardIn1Src, vecs[i].x_f1);
      chk($sformatf("vec%0d_fwd2", i), Eo_forwardIn2Src, vecs[i].x_f2);
      chk($sformatf("vec%0d_Fstall", i), Fo_stall, vecs[i].x_st);
      chk($sformatf("vec%0d_Dstall", i), Do_stall, vecs[i].x_st);
      chk($sformatf("vec%0d_Dflush", i), Do_flush, vecs[i].x_df);
      chk($sformatf("vec%0d_Eflush", i), Eo_flush, vecs[i].x_ef);
      adv();
    end

    // Long op to x7 with a dependent D instruction; release one cycle after completion.
    idle();
    issue(7); Di_rs1 = 5'd7; Di_rd = 5'd8; Di_regWrite = 1;
    settle(); chk("long_issue_stall", Do_stall, 1); chk("long_issue_eflush", Eo_flush, 1);
    adv();
    Ei_longOp = 0; Ei_regWrite = 0; Ei_rd = '0;
    settle(); chk("long_busy_stall", Do_stall, 1); chk("long_busy_count", o_busyCount, 1);
    adv();
    settle(); chk("long_hold_stall", Fo_stall, 1);
    adv();
    done(7);
    settle(); chk("long_done_cycle_stall", Do_stall, 1);
    adv();
    Li_done = 0;
    settle(); chk("long_release_stall", Do_stall, 0); chk("long_release_count", o_busyCount, 0);
    adv();

    // Capacity: fill to MAX, D long op waits until one completion has landed.
    idle();
    for (int r = 1; r <= MAX; r++) begin
      issue(r);
      if (r == MAX) begin Di_longOp = 1; Di_rd = 5'd10; Di_regWrite = 1; end
      settle();
      if (r == MAX) chk("cap_full_with_E_issue", Do_stall, 1);
      adv();
    end
    Ei_longOp = 0; Ei_regWrite = 0; Ei_rd = '0;
    settle(); chk("cap_full_stall", Do_stall, 1); chk("cap_count_max", o_busyCount, MAX);
    adv();
    done(1);
    settle(); chk("cap_done_cycle_stall", Do_stall, 1);
    adv();
    Li_done = 0;
    settle(); chk("cap_release", Do_stall, 0); chk("cap_count_after_done", o_busyCount, MAX - 1);
    adv();
    idle(); issue(10);
    settle(); adv();
    idle();
    settle(); chk("cap_count_refill", o_busyCount, MAX);
    adv();
    foreach (pend[i]) begin
      done(pend[0]);
      settle(); adv();
    end
    while (pend.size() > 0) begin
      done(pend[0]);
      settle(); adv();
    end
    idle();
    settle(); chk("cap_drained", o_busyCount, 0);
    adv();

    // Same-cycle completion and reissue to x4.
    issue(4); settle(); adv();
    idle(); issue(4); done(4);
    settle(); adv();
    idle(); Di_rs1 = 5'd4;
    settle(); chk("setclr_busy_stall", Do_stall, 1); chk("setclr_count", o_busyCount, 1);
    adv();
    idle(); done(4); settle(); adv();
    idle(); settle(); chk("setclr_drained", o_busyCount, 0); adv();

    // Stray completion raises a sticky error.
    done(9);
    settle(); chk("err_before_edge", o_sbError, 0);
    adv();
    idle();
    for (int k = 0; k < 3; k++) begin
      settle(); chk("err_sticky", o_sbError, 1);
      adv();
    end

    // Asynchronous reset with three ops outstanding, no clock edge in between.
    for (int r = 1; r <= 3; r++) begin issue(r); settle(); adv(); end
    idle(); Di_rs1 = 5'd1;
    settle(); chk("pre_rst_count", o_busyCount, 3); chk("pre_rst_stall", Do_stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_count", o_busyCount, 0);
    chk("async_rst_error", o_sbError, 0);
    chk("async_rst_stall", Do_stall, 0);
    pend.delete(); err_m = 1'b0;
    #1 rst = 1'b0;
    adv();

    // Completion for x0 is always an error.
    idle(); done(0); settle(); adv();
    idle(); settle(); chk("err_x0", o_sbError, 1); adv();

    rst = 1'b1; #1; rst = 1'b0;
    pend.delete(); err_m = 1'b0;
    adv();

    // Randomized traffic under a legal long-unit environment.
    for (int c = 0; c < 3000; c++) begin
      int rd;
      idle();
      Di_rs1 = 5'($urandom_range(0, 7)); Di_rs2 = 5'($urandom_range(0, 7));
      Di_rd = 5'($urandom_range(0, 7)); Di_regWrite = 1'($urandom_range(0, 1));
      Di_longOp = ($urandom_range(0, 3) == 0);
      Ei_rs1 = 5'($urandom_range(0, 7)); Ei_rs2 = 5'($urandom_range(0, 7));
      Ei_rd = 5'($urandom_range(0, 7)); Ei_resultSrc = 2'($urandom_range(0, 2));
      Ei_regWrite = 1'($urandom_range(0, 1));
      Ei_PCSrc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      Mi_rd = 5'($urandom_range(0, 7)); Mi_resultSrc = 2'($urandom_range(0, 3));
      Mi_regWrite = 1'($urandom_range(0, 1));
      Wi_rd = 5'($urandom_range(0, 7)); Wi_regWrite = 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0 && pend.size() < MAX && !is_busy(rd)) begin
        Ei_longOp = 1; Ei_rd = 5'(rd);
      end
      if (pend.size() > 0 && $urandom_range(0, 2) == 0)
        done(pend[$urandom_range(0, pend.size() - 1)]);
      else if ($urandom_range(0, 60) == 0)
        done($urandom_range(0, 7));
      if (Li_done && Ei_longOp && Ei_regWrite && Li_rd == Ei_rd && !is_busy(int'(Ei_rd)))
        Li_done = 0;
      settle();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Next-generation pipeline hazard unit for the 5-stage core (F/D/E/M/W), parametrised in register-index width and long-latency capacity.
- Keeps the existing forwarding, load-use stall and branch-flush functions.
- Adds a register scoreboard (per-register busy bits plus an outstanding counter) for multi-cycle ops such as mul/div, which issue from E and complete out of order.
- Sits beside the controller/datapath; all stall, flush and forward selects come from here.

Parameters:
REG_AW, 5, register index width; the register file has 2**REG_AW entries, and x0 is never tracked.
MAX_OUTSTANDING, 4, max concurrently outstanding long-latency ops (1..2**REG_AW-1).
CW, $clog2(MAX_OUTSTANDING+1), counter width (derived, localparam).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
Di_rs1, Di_rs2, Di_rd  in  REG_AW each  D-stage register indices
Di_regWrite  in  1  D instruction writes rd
Di_longOp  in  1  D instruction is a long-latency op
Ei_rs1, Ei_rs2, Ei_rd  in  REG_AW each  E-stage register indices
Ei_resultSrc  in  2  00 ALU, 01 load, 10 immPlus
Ei_regWrite  in  1  E instruction writes rd
Ei_longOp  in  1  E instruction is a valid long op issuing this cycle
Ei_PCSrc  in  2  00 = PC+4, else redirect
Mi_rd  in  REG_AW  M-stage destination
Mi_resultSrc  in  2  M-stage result source
Mi_regWrite  in  1  M-stage write enable
Wi_rd  in  REG_AW  W-stage destination
Wi_regWrite  in  1  W-stage write enable
Li_done  in  1  long unit completes (writes RF) this cycle
Li_rd  in  REG_AW  destination of completing long op
Eo_forwardIn1Src, Eo_forwardIn2Src  out  2 each  00 RD, 01 W result, 10 M immPlus, 11 M ALUOut
Fo_stall, Do_stall  out  1 each  hold F/D registers
Do_flush, Eo_flush  out  1 each  bubble D/E registers
o_busyCount  out  CW  outstanding long ops (registered)
o_sbError  out  1  sticky: completion for a non-busy register (registered)

Behaviour:
- Reset (async, rst=1): busy vector = 0, o_busyCount = 0, o_sbError = 0. Combinational outputs are evaluated with busy = 0.
- Forwarding (combinational, per operand n):
  - rs == 0 → 00.
  - else rs == Mi_rd & Mi_regWrite & resultSrc == 00 → 11.
  - else same M match with resultSrc == 10 → 10.
  - else rs == Wi_rd & Wi_regWrite → 01.
  - else 00.
  - An M match with resultSrc == 01 falls through to the W check. The select is always fully defined; there is no latch path.
- Stall sources (combinational):
  - loadUse: Ei_resultSrc == 01 & Ei_regWrite & Ei_rd != 0 & Ei_rd ∈ {Di_rs1, Di_rs2}.
  - longRAW: (busy[Di_rs1] & Di_rs1 != 0) | (busy[Di_rs2] & Di_rs2 != 0) | (Ei_longOp & Ei_rd != 0 & Ei_rd ∈ {Di_rs1, Di_rs2}).
  - longWAW: Di_regWrite & Di_rd != 0 & (busy[Di_rd] | (Ei_longOp & Ei_rd == Di_rd)).
  - full: Di_longOp & (o_busyCount + Ei_longOp) >= MAX_OUTSTANDING.
  - anyStall = OR of the four sources.
- Busy bits are not cleared by Li_done until the edge. A dependent D instruction therefore stays stalled during the Li_done cycle and is released the following cycle, when it reads the updated RF.
- Outputs:
  - branch = (Ei_PCSrc != 00).
  - Fo_stall = Do_stall = anyStall & !branch (a redirect kills the stalled D instruction).
  - Do_flush = branch.
  - Eo_flush = branch | anyStall.
- Scoreboard update (at posedge):
  - set = Ei_longOp & Ei_regWrite & Ei_rd != 0.
  - clr = Li_done & busy[Li_rd].
  - busy[Ei_rd] ← 1 on set; busy[Li_rd] ← 0 on clr. Set and clear of the same index → set wins.
  - o_busyCount += set − clr. The counter never wraps: set while the count equals MAX is prevented by the full stall.
  - Li_done with busy[Li_rd] == 0, or Li_rd == 0 → no state change, o_sbError ← 1 (sticky until reset).
- Flushes never clear busy bits; issued long ops always complete.
- Reset asserted mid-operation discards all outstanding tracking immediately. The long unit is reset by the same rst.

Decomposition:
- hazard_pkg: resultSrc encodings (RES_ALU, RES_LOAD, RES_IMMPLUS), forward-select encodings (FWD_RD, FWD_WB, FWD_MIMM, FWD_MALU), PCSRC_PLUS4.
- One sub-module, hazard_scoreboard: clk, rst, set/set_rd, clr/clr_rd, read ports for rs1/rs2/rd, busyCount, error. It is parametrised by REG_AW and MAX_OUTSTANDING.
- Forwarding and stall/flush logic stay in hazard_unit_sb.

Test Plan:
- Forwarding: E rs1 = 5, M rd = 5 ALU regWrite, W rd = 5 → fwd1 = 11; M resultSrc = 10 → 10; M regWrite = 0 → 01; rs1 = 0 → 00.
- Load-use: E load rd = 3, D rs2 = 3 → Fo/Do_stall = 1, Eo_flush = 1 for one cycle. Same setup plus Ei_PCSrc = 01 → stalls 0, Do_flush = Eo_flush = 1.
- Long op: E longOp rd = 7, D rs1 = 7 → stall. The next cycles show busy[7] set and count = 1, with stall held. Li_done rd = 7 → stall still 1 that cycle, 0 the next, count = 0.
- Capacity: MAX_OUTSTANDING = 2, issue long ops to x1 and x2, then a D longOp → stall. One Li_done → the D longOp issues the next cycle; count never exceeds 2.
- Same-cycle set/clear: x4 busy; Li_done rd = 4 while E issues a long op to x4 → busy[4] stays 1, count unchanged.
- Error/reset: Li_done rd = 9 with x9 not busy → o_sbError = 1, sticky. Async rst mid-run with count = 3 → count = 0, busy = 0, error = 0 without a clock edge.
